// File: rtl/mem_port_pkg.sv
// Shared constants and types for the memory port controller.
// The CLEAR state is only used when MEM_PORT_CTRL_CLEAR_EN is defined.
package mem_port_pkg;

  localparam int AW_DEF         = 4;
  localparam int DW_DEF         = 8;
  localparam int RSP_FIFO_DEPTH = 2;
  localparam int RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/mem_port_rsp_fifo.sv
// Two-entry read-response FIFO with show-ahead head output.
// The controller's credit scheme guarantees it is never pushed while full.
module mem_port_rsp_fifo
  import mem_port_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DW-1:0]        push_dat,
  input  logic                 pop,
  output logic                 not_empty,
  output logic [RSP_CNT_W-1:0] count,
  output logic [DW-1:0]        head_dat
);

  localparam int PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  logic [DW-1:0]        data_q [RSP_FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [RSP_CNT_W-1:0] count_q, count_d;
  logic                 do_push, do_pop, full;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) data_q[wr_ptr_q] <= push_dat;
  end

  assign full      = (count_q == RSP_CNT_W'(RSP_FIFO_DEPTH));
  assign not_empty = (count_q != '0);
  assign count     = count_q;
  assign head_dat  = data_q[rd_ptr_q];

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-port memory front end: combinational request path, 2-cycle read
// latency, credit-limited 2-entry response FIFO. Optional MEM_PORT_CTRL_CLEAR_EN.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_adr,
  input  logic [DW-1:0] req_dat,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dat,
  output logic [AW-1:0] mem_adr,
  output logic          mem_we,
  output logic [DW-1:0] mem_dat_w,
  input  logic [DW-1:0] mem_dat_r,
  output logic          busy
);

  localparam logic [RSP_CNT_W:0] CREDITS = (RSP_CNT_W + 1)'(RSP_FIFO_DEPTH);

  logic                 clearing, in_run;
  logic                 inflight_q, inflight_d;
  logic                 fifo_pop;
  logic [RSP_CNT_W-1:0] fifo_count;
  logic [RSP_CNT_W:0]   occupancy;
  logic                 credit_ok, accept;

`ifdef MEM_PORT_CTRL_CLEAR_EN
  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The counter wraps back to 0 on the last clear cycle, ready for the next reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) state_d = RUN;
    end
  end

  assign clearing = (state_q == CLEAR);
`else
  assign clearing = 1'b0;
`endif

  assign in_run = rst && !clearing;
  assign busy   = clearing;

  // A response leaving this cycle frees its slot for a read accepted this cycle.
  always_comb begin
    fifo_pop   = rsp_valid && rsp_ready;
    occupancy  = {1'b0, fifo_count} + (RSP_CNT_W + 1)'(inflight_q)
               - (RSP_CNT_W + 1)'(fifo_pop);
    credit_ok  = (occupancy < CREDITS);
    req_ready  = in_run && (req_we || credit_ok);
    accept     = req_valid && req_ready;
    inflight_d = accept && !req_we;
    mem_adr    = req_adr;
    mem_dat_w  = req_dat;
    mem_we     = accept && req_we;
`ifdef MEM_PORT_CTRL_CLEAR_EN
    if (clearing) begin
      mem_adr   = clr_cnt_q;
      mem_dat_w = '0;
      mem_we    = rst;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inflight_q <= 1'b0;
    else      inflight_q <= inflight_d;
  end

  mem_port_rsp_fifo #(
    .DW (DW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_dat  (mem_dat_r),
    .pop       (fifo_pop),
    .not_empty (rsp_valid),
    .count     (fifo_count),
    .head_dat  (rsp_dat)
  );

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a synchronous memory model and a
// response scoreboard. Covers both builds of MEM_PORT_CTRL_CLEAR_EN.
module tb_mem_port_ctrl;
  import mem_port_pkg::*;

  localparam int AW = AW_DEF;
  localparam int DW = DW_DEF;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic [AW-1:0] mem_adr;
  logic          mem_we;
  logic [DW-1:0] mem_dat_w, mem_dat_r;
  logic          busy;
  logic          preload = 1'b1;

  logic [DW-1:0] tb_mem [NW];
  logic [DW-1:0] shadow [NW];
  logic [DW-1:0] exp_q [$];
  int            total = 0;
  int            bad = 0;
  int            n_rsp = 0;

  always #5 clk = ~clk;

  mem_port_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .mem_adr   (mem_adr),
    .mem_we    (mem_we),
    .mem_dat_w (mem_dat_w),
    .mem_dat_r (mem_dat_r),
    .busy      (busy)
  );

  function automatic logic [DW-1:0] img(input int i);
    return (i == 3) ? DW'(32'hFE) : DW'(i * 19 + 33);
  endfunction

  function automatic logic [DW-1:0] wval(input int i);
    return DW'(32'hC0 + i * 7);
  endfunction

  // Single-port synchronous RAM: read data valid one cycle after the address.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NW; i++) tb_mem[i] <= img(i);
    end else begin
      if (mem_we) tb_mem[mem_adr] <= mem_dat_w;
      mem_dat_r <= tb_mem[mem_adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on consumed responses, push on accepted reads.
  task automatic mon();
    logic [DW-1:0] e;
    if (rst) begin
      if (rsp_valid && rsp_ready) begin
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL rsp_unexpected: observed response 0x%0h expected none", rsp_dat);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("rsp #%0d dat=0x%02h exp=0x%02h", n_rsp, rsp_dat, e);
          chk("rsp_dat", 32'(rsp_dat), 32'(e));
          n_rsp++;
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          shadow[req_adr] = req_dat;
          $display("req wr adr=%0d dat=0x%02h", req_adr, req_dat);
        end else begin
          exp_q.push_back(shadow[req_adr]);
          $display("req rd adr=%0d", req_adr);
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      adv();
    end
  endtask

  task automatic set_req(input logic v, input logic we, input int adr, input int dat);
    req_valid = v;
    req_we    = we;
    req_adr   = AW'(adr);
    req_dat   = DW'(dat);
  endtask

  task automatic clear_loop(input int n);
    for (int k = 0; k < n; k++) begin
      sample();
      chk("clr_busy", 32'(busy), 1);
      chk("clr_mem_we", 32'(mem_we), 1);
      chk("clr_dat", 32'(mem_dat_w), 0);
      chk("clr_adr", 32'(mem_adr), k);
      chk("clr_req_ready", 32'(req_ready), 0);
      adv();
    end
  endtask

  task automatic clear_full();
    set_req(1'b1, 1'b1, NW - 1, 32'hFF);
    clear_loop(NW);
    set_req(1'b0, 1'b0, 0, 0);
    sample();
    chk("clr_done_busy", 32'(busy), 0);
    chk("clr_done_ready", 32'(req_ready), 1);
    adv();
    for (int i = 0; i < NW; i++) shadow[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(1'b0, 1'b0, 0, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < NW; i++) shadow[i] = img(i);
    adv();
    adv();
    sample();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    preload = 1'b0;
    adv();
    rst = 1'b1;

`ifdef MEM_PORT_CTRL_CLEAR_EN
    // Interrupt clearing at count 7, then expect a full restart from 0.
    set_req(1'b1, 1'b1, NW - 1, 32'hFF);
    clear_loop(7);
    sample();
    chk("clr_adr7", 32'(mem_adr), 7);
    rst = 1'b0;
    #1;
    chk("clr_rst_mem_we", 32'(mem_we), 0);
    adv();
    adv();
    rst = 1'b1;
    clear_full();
`else
    sample();
    chk("run_busy", 32'(busy), 0);
    chk("run_req_ready", 32'(req_ready), 1);
    adv();
`endif

    // Read latency: read adr 3 at cycle N, response at N+2.
    set_req(1'b1, 1'b0, 3, 0);
    sample();
    chk("lat_req_ready", 32'(req_ready), 1);
    chk("lat_mem_adr", 32'(mem_adr), 3);
    chk("lat_mem_we", 32'(mem_we), 0);
    adv();
    set_req(1'b0, 1'b0, 0, 0);
    sample();
    chk("lat_n1_valid", 32'(rsp_valid), 0);
    adv();
    sample();
    chk("lat_n2_valid", 32'(rsp_valid), 1);
`ifdef MEM_PORT_CTRL_CLEAR_EN
    chk("lat_n2_dat", 32'(rsp_dat), 32'h00);
`else
    chk("lat_n2_dat", 32'(rsp_dat), 32'hFE);
`endif
    adv();

    // Write adr 5 then read it back the next cycle.
    set_req(1'b1, 1'b1, 5, 32'hA5);
    sample();
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_adr", 32'(mem_adr), 5);
    chk("wr_mem_dat", 32'(mem_dat_w), 32'hA5);
    adv();
    set_req(1'b1, 1'b0, 5, 0);
    sample();
    adv();
    set_req(1'b0, 1'b0, 0, 0);
    sample();
    chk("wr_no_rsp", 32'(rsp_valid), 0);
    adv();
    sample();
    chk("raw_valid", 32'(rsp_valid), 1);
    chk("raw_dat", 32'(rsp_dat), 32'hA5);
    adv();

    // Known data at 0..7, then back-to-back reads with rsp_ready held high.
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 1'b1, i, 32'(wval(i)));
      sample();
      chk("fill_ready", 32'(req_ready), 1);
      adv();
    end
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 1'b0, i, 0);
      sample();
      chk("b2b_ready", 32'(req_ready), 1);
      adv();
    end
    set_req(1'b0, 1'b0, 0, 0);
    idle(3);
    chk("b2b_drained", 32'(exp_q.size()), 0);

    // Backpressure: two reads fill the credits, the third waits.
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 0, 0);
    sample();
    chk("bp_ready0", 32'(req_ready), 1);
    adv();
    set_req(1'b1, 1'b0, 1, 0);
    sample();
    chk("bp_ready1", 32'(req_ready), 1);
    adv();
    set_req(1'b1, 1'b0, 2, 0);
    sample();
    chk("bp_ready2", 32'(req_ready), 0);
    chk("bp_valid", 32'(rsp_valid), 1);
    chk("bp_dat", 32'(rsp_dat), 32'(wval(0)));
    adv();
    sample();
    chk("bp_ready3", 32'(req_ready), 0);
    chk("bp_hold", 32'(rsp_dat), 32'(wval(0)));
    adv();
    rsp_ready = 1'b1;
    sample();
    chk("bp_release_ready", 32'(req_ready), 1);
    adv();
    set_req(1'b0, 1'b0, 0, 0);
    idle(4);
    chk("bp_drained", 32'(exp_q.size()), 0);
    chk("rsp_count", 32'(n_rsp), 13);

    // Reset with one read in flight and one queued response.
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 1, 0);
    sample();
    adv();
    set_req(1'b1, 1'b0, 2, 0);
    sample();
    adv();
    set_req(1'b0, 1'b0, 0, 0);
    sample();
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rsp_valid), 0);
    chk("rst_async_mem_we", 32'(mem_we), 0);
    exp_q.delete();
    adv();
    adv();
    rst = 1'b1;
`ifdef MEM_PORT_CTRL_CLEAR_EN
    clear_full();
`endif
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("post_rst_no_rsp", 32'(rsp_valid), 0);
      adv();
    end
    set_req(1'b1, 1'b0, 1, 0);
    sample();
    adv();
    set_req(1'b0, 1'b0, 0, 0);
    idle(3);
    chk("final_drained", 32'(exp_q.size()), 0);
    chk("final_rsp_count", 32'(n_rsp), 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
